// File: rtl/mips_main_control_fsm_if.sv
// ---------------------------------------------------------------------------
// mips_main_control_fsm_if
//
// Bundle of everything that passes between the multicycle main control FSM
// and the 32-bit MIPS datapath. The clock and reset are not part of the bundle.
//
//   Datapath -> control : Opcode[5:0] (IR[31:26]), Zero (ALU zero flag),
//                         mem_ready (memory completes its access this cycle)
//   Control -> datapath : PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//                         RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], AluOp1,
//                         AluOp0, PCSource[1:0], illegal_op, state[3:0] (debug)
//
// Modports: master = control FSM side, slave = datapath side.
// ---------------------------------------------------------------------------
interface mips_main_control_fsm_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       mem_ready;

    logic       PCEn;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       AluOp1;
    logic       AluOp0;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  Opcode, Zero, mem_ready,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, AluOp1, AluOp0, PCSource,
               illegal_op, state
    );

    modport slave (
        output Opcode, Zero, mem_ready,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, AluOp1, AluOp0, PCSource,
               illegal_op, state
    );
endinterface

// File: rtl/mips_main_control_fsm.sv
// ---------------------------------------------------------------------------
// mips_main_control_fsm
//
// Multicycle main control unit for the 32-bit MIPS datapath. Each instruction
// walks FETCH -> DECODE -> (execute / memory / writeback) -> FETCH. The memory
// states FETCH, MEMRD and MEMWR stall until mem_ready.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (forces FETCH, all strobes 0)
//   bus    : mips_main_control_fsm_if.master (opcode/flags in, strobes out)
//
// Optional feature: define BNE_EN to accept bne (opcode 000101). It shares
// the BRANCH state with beq; the branch condition is inverted for bne.
//
// State-derived controls are registered (loaded from the next state). The
// strobes that the datapath must see in the same cycle as mem_ready or Zero
// (IRWrite, PCEn) and the illegal_op pulse are qualified combinationally.
// ---------------------------------------------------------------------------
module mips_main_control_fsm (
    input  logic                           clk,
    input  logic                           rst_n,
    mips_main_control_fsm_if.master        bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // Per-state control word. pc_write_fetch is the FETCH PC increment that
    // only takes effect in the mem_ready cycle; pc_write_cond is the branch
    // update that depends on the branch outcome.
    typedef struct packed {
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_fetch;
        logic       pc_write_cond;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read       = 1'b1;
                c.ir_write       = 1'b1;
                c.pc_write_fetch = 1'b1;
                c.alu_src_b      = 2'b01;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_source     = 2'b01;
                c.pc_write_cond = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;
    logic   opcode_legal;
    logic   branch_taken;
    logic   state_valid;
    logic   strobe_en;

    always_comb begin
        opcode_legal = 1'b0;
        case (bus.Opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_legal = 1'b1;
`ifdef BNE_EN
            OP_BNE:                                        opcode_legal = 1'b1;
`endif
            default:                                       opcode_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
`ifdef BNE_EN
                    OP_BNE:       state_next = S_BRANCH;
`endif
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.Opcode == OP_LW)
                    state_next = S_MEMRD;
                else if (bus.Opcode == OP_SW)
                    state_next = S_MEMWR;
                else
                    state_next = S_FETCH;
            end
            S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Controls are loaded from the state being entered, so they line up with
    // state_reg in the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            ctrl_reg  <= ctrl_for(S_FETCH);
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_for(state_next);
        end
    end

`ifdef BNE_EN
    assign branch_taken = (bus.Opcode == OP_BNE) ? ~bus.Zero : bus.Zero;
`else
    assign branch_taken = bus.Zero;
`endif

    // A corrupted state code (12-15) must not issue any strobe, even though
    // the registered control word may still hold an older state's values.
    assign state_valid = (state_reg <= S_JUMP);
    assign strobe_en   = rst_n & state_valid;

    assign bus.PCEn       = strobe_en & (ctrl_reg.pc_write
                                       | (ctrl_reg.pc_write_fetch & bus.mem_ready)
                                       | (ctrl_reg.pc_write_cond & branch_taken));
    assign bus.IRWrite    = strobe_en & ctrl_reg.ir_write & bus.mem_ready;
    assign bus.MemRead    = strobe_en & ctrl_reg.mem_read;
    assign bus.MemWrite   = strobe_en & ctrl_reg.mem_write;
    assign bus.RegWrite   = strobe_en & ctrl_reg.reg_write;
    assign bus.illegal_op = rst_n & (state_reg == S_DECODE) & ~opcode_legal;

    assign bus.IorD     = ctrl_reg.ior_d;
    assign bus.MemtoReg = ctrl_reg.mem_to_reg;
    assign bus.RegDst   = ctrl_reg.reg_dst;
    assign bus.ALUSrcA  = ctrl_reg.alu_src_a;
    assign bus.ALUSrcB  = ctrl_reg.alu_src_b;
    assign bus.AluOp1   = ctrl_reg.alu_op[1];
    assign bus.AluOp0   = ctrl_reg.alu_op[0];
    assign bus.PCSource = ctrl_reg.pc_source;
    assign bus.state    = state_reg;

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mips_main_control_fsm
//
// Random instruction stream for mips_main_control_fsm. Each instruction is
// expanded into its list of visited states, memory stalls are inserted
// randomly, and every cycle the DUT state and control outputs are compared
// against a per-state output table. Random resets are injected mid-instruction.
// ---------------------------------------------------------------------------
module tb_mips_main_control_fsm;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mips_main_control_fsm_if bus();

    mips_main_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef BNE_EN
    localparam bit BNE_ON = 1'b1;
`else
    localparam bit BNE_ON = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) ||
               (op == 6'd8) || (op == 6'd2) || (BNE_ON && op == 6'd5);
    endfunction

    // {IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
    //  ALUSrcB[1:0], AluOp1, AluOp0, PCSource[1:0], PCEn, illegal_op}
    function automatic logic [15:0] observed();
        return {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
                bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.AluOp1,
                bus.AluOp0, bus.PCSource, bus.PCEn, bus.illegal_op};
    endfunction

    // Expected outputs of one cycle in state st. Strobes are always checked;
    // a mux select is checked only in the states that define it.
    task automatic expect_cycle(input int st, input logic [5:0] op, input logic z,
                                input logic rdy, output logic [15:0] val,
                                output logic [15:0] mask);
        logic iord, mr, mw, irw, m2r, rdst, rw, asa, pce, ill;
        logic [1:0] asb, aop, pcs;
        logic m_iord, m_m2r, m_rdst, m_asa, m_asb, m_aop, m_pcs;
        {iord, mr, mw, irw, m2r, rdst, rw, asa, pce, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        {m_iord, m_m2r, m_rdst, m_asa, m_asb, m_aop, m_pcs} = '0;
        case (st)
            0: begin
                mr = 1; irw = rdy; pce = rdy;
                m_iord = 1; m_asa = 1; asb = 2'b01; m_asb = 1; m_aop = 1; m_pcs = 1;
            end
            1: begin
                m_asa = 1; asb = 2'b11; m_asb = 1; m_aop = 1; ill = !is_legal(op);
            end
            2: begin asa = 1; m_asa = 1; asb = 2'b10; m_asb = 1; m_aop = 1; end
            3: begin mr = 1; iord = 1; m_iord = 1; end
            4: begin rw = 1; m2r = 1; m_m2r = 1; m_rdst = 1; end
            5: begin mw = 1; iord = 1; m_iord = 1; end
            6: begin asa = 1; m_asa = 1; m_asb = 1; aop = 2'b10; m_aop = 1; end
            7: begin rw = 1; rdst = 1; m_rdst = 1; m_m2r = 1; end
            8: begin
                asa = 1; m_asa = 1; m_asb = 1; aop = 2'b01; m_aop = 1;
                pcs = 2'b01; m_pcs = 1;
                pce = (BNE_ON && op == 6'd5) ? !z : z;
            end
            9: begin asa = 1; m_asa = 1; asb = 2'b10; m_asb = 1; m_aop = 1; end
            10: begin rw = 1; m_rdst = 1; m_m2r = 1; end
            11: begin pcs = 2'b10; m_pcs = 1; pce = 1; end
            default: ;
        endcase
        val  = {iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, pcs, pce, ill};
        mask = {m_iord, 1'b1, 1'b1, 1'b1, m_m2r, m_rdst, 1'b1, m_asa,
                {2{m_asb}}, {2{m_aop}}, {2{m_pcs}}, 1'b1, 1'b1};
    endtask

    // States an instruction visits with no memory stalls.
    task automatic build_recipe(input logic [5:0] op, output int rec[$]);
        rec = {0, 1};
        if (is_legal(op)) begin
            case (op)
                6'd35:       rec = {rec, 2, 3, 4};
                6'd43:       rec = {rec, 2, 5};
                6'd0:        rec = {rec, 6, 7};
                6'd4, 6'd5:  rec = {rec, 8};
                6'd8:        rec = {rec, 9, 10};
                6'd2:        rec = {rec, 11};
                default:     ;
            endcase
        end
    endtask

    // Reset asserted between clock edges: state and strobes drop at once and
    // stay down across a clock edge; release happens on a falling edge.
    task automatic do_reset();
        logic [15:0] rst_val;
        rst_val = 16'h0040;              // ALUSrcB=01, everything else 0
        rst_n = 1'b0;
        #1;
        check_eq("rst_state", 32'(bus.state), 32'd0);
        check_eq("rst_outs", 32'(observed() & 16'hF3FF), 32'(rst_val));
        @(negedge clk);
        check_eq("rst_hold_state", 32'(bus.state), 32'd0);
        check_eq("rst_hold_outs", 32'(observed() & 16'hF3FF), 32'(rst_val));
        rst_n = 1'b1;
    endtask

    // Runs one instruction; called just after a falling edge with the DUT in
    // FETCH. reset_at >= 0 injects a reset in that cycle of the instruction.
    task automatic run_instr(input logic [5:0] op, input int reset_at, input bit never_stall);
        int rec[$];
        int cyc;
        int stalls;
        bit stall;
        logic rdy, z;
        logic [15:0] ev, em;
        build_recipe(op, rec);
        cyc = 0;
        foreach (rec[i]) begin
            stalls = 0;
            do begin
                rdy = never_stall || (stalls >= 5) || ($urandom_range(0, 9) < 7);
                z   = 1'($urandom_range(0, 1));
                bus.mem_ready = rdy;
                bus.Zero      = z;
                bus.Opcode    = (rec[i] == 1 || rec[i] == 2 || rec[i] == 8)
                                ? op : 6'($urandom_range(0, 63));
                if (cyc == reset_at) begin
                    do_reset();
                    $display("instr op=%b reset injected in cycle %0d", op, cyc);
                    return;
                end
                #1;
                expect_cycle(rec[i], op, z, rdy, ev, em);
                check_eq("state", 32'(bus.state), 32'(rec[i]));
                check_eq("outs", 32'(observed() & em), 32'(ev));
                stall = (rec[i] == 0 || rec[i] == 3 || rec[i] == 5) && !rdy;
                @(negedge clk);
                cyc++;
                stalls++;
            end while (stall);
        end
        $display("instr op=%b cycles=%0d", op, cyc);
    endtask

    logic [5:0] legal_ops [7];
    logic [5:0] op;

    initial begin
        legal_ops = '{6'd35, 6'd43, 6'd0, 6'd4, 6'd8, 6'd2, 6'd5};
        rst_n = 1'b0;
        bus.Opcode = 6'd0;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("init_state", 32'(bus.state), 32'd0);
        check_eq("init_outs", 32'(observed() & 16'hF3FF), 32'h0040);
        rst_n = 1'b1;

        // Ready-high latency of each class, then illegal and bne.
        run_instr(6'd35, -1, 1'b1);
        run_instr(6'd43, -1, 1'b1);
        run_instr(6'd0,  -1, 1'b1);
        run_instr(6'd4,  -1, 1'b1);
        run_instr(6'd8,  -1, 1'b1);
        run_instr(6'd2,  -1, 1'b1);
        run_instr(6'd63, -1, 1'b1);
        run_instr(6'd5,  -1, 1'b1);
        run_instr(6'd0,  2,  1'b1);      // reset while in EXEC

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0)
                op = 6'($urandom_range(0, 63));
            else
                op = legal_ops[$urandom_range(0, 6)];
            run_instr(op, ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 4)) : -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_main_control_fsm.md
Name: mips_main_control_fsm

Overview:
- Multicycle main control unit for the 32-bit MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath strobes and the AluOp1/AluOp0 pair consumed by the ALU control decoder.
- Sits between the instruction register opcode field and the datapath muxes and enables; stalls on a memory ready handshake.

Parameters:
- none (encodings fixed; see Behaviour)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- Opcode  input  6  IR[31:26]
- Zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current access this cycle
- PCEn  output  1  PC load enable (PCWrite | PCWriteCond&branch_taken)
- IorD  output  1  0=PC address, 1=ALUOut address
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load instruction register
- MemtoReg  output  1  1=MDR to register file
- RegDst  output  1  1=rd, 0=rt
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0=PC, 1=regA
- ALUSrcB  output  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- AluOp1  output  1  ALU op high bit
- AluOp0  output  1  ALU op low bit
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- state  output  4  current state (debug)

Behaviour:
- {AluOp1,AluOp0} encoding: 00=add, 01=subtract, 10=R-type funct field, 11=OR (reserved, never driven).
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Reset: rst_n low forces state=FETCH asynchronously. While rst_n is low, all strobes are forced to 0 (PCEn, MemRead, MemWrite, IRWrite, RegWrite, illegal_op); mux selects take their FETCH values.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOp=00, PCSource=00.
  - IRWrite=1 and PCEn=1 only in the cycle mem_ready=1.
  - Holds while mem_ready=0; otherwise goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, AluOp=00 (branch target precompute).
  - Next state: lw/sw->MEMADR, R->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP.
  - Any other opcode->FETCH with illegal_op=1 for this cycle; no state write occurs.
- MEMADR: ALUSrcA=1, ALUSrcB=10, AluOp=00. lw->MEMRD, sw->MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then FETCH.
  - MemWrite stays high while stalled; exactly one completing cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, AluOp=10. Next ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, AluOp=01, PCSource=01.
  - PCEn=Zero (combinational, same cycle). Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, AluOp=00. Next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- JUMP: PCSource=10, PCEn=1. Next FETCH.
- Defaults: every strobe not listed is 0 in that state.
- Latency with mem_ready tied high: lw 5 cycles, sw 4, R 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle adds one cycle in FETCH/MEMRD/MEMWR.
- Opcode is sampled only in DECODE, MEMADR and BRANCH. The IR is stable after FETCH, so changes elsewhere are ignored.
- Unreachable state codes 12-15 -> FETCH on the next clock, all strobes 0.
- Reset mid-instruction: the next state after release is FETCH. No partial RegWrite/MemWrite may be issued.

Optional Feature:
- Macro BNE_EN.
- Defined: adds opcode bne 000101. DECODE->BRANCH; in BRANCH, PCEn=~Zero for bne and PCEn=Zero for beq. The opcode is re-examined in BRANCH.
- Undefined: 000101 is illegal (illegal_op pulse in DECODE, return to FETCH).

Test Plan:
- Reset: assert rst_n=0 in EXEC -> state=0 immediately, all strobes 0. Release -> FETCH with MemRead=1.
- lw (100011), mem_ready=1 -> states 0,1,2,3,4,0. MEMWB shows RegWrite=1, MemtoReg=1. AluOp=00 in MEMADR.
- R-type (000000) -> states 0,1,6,7,0. AluOp1=1, AluOp0=0 in EXEC. RegDst=1, RegWrite=1 in ALUWB.
- beq with Zero=1 -> PCEn=1, PCSource=01, AluOp=01 in BRANCH. With Zero=0 -> PCEn=0. Both return to FETCH after 3 cycles.
- sw with mem_ready low 3 cycles in MEMWR -> MemWrite high 4 cycles, state held at 5, then FETCH. Same stall in FETCH -> IRWrite/PCEn asserted only in the ready cycle.
- Opcode 111111 -> illegal_op pulses 1 cycle in DECODE, next state FETCH, no RegWrite/MemWrite. With BNE_EN, 000101 and Zero=0 -> PCEn=1.
